// File: rtl/pp_fifo_arb_pkg.sv
// pp_fifo_arb_pkg: shared FSM state type and beat-counter width for the FIFO write arbiter
package pp_fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  localparam int ARB_CNT_W = 4;
endpackage

// File: rtl/pp_rr_pick.sv
// pp_rr_pick: combinational round-robin pick of the first masked requester at or after start_i
module pp_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  logic [N-1:0] cand;
  assign cand = req_i & mask_i;
  // scan from farthest to nearest so the nearest candidate is the one that sticks
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[(int'(start_i) + k) % N]) begin
        idx_o = IW'((int'(start_i) + k) % N);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pp_fifo_wr_arbiter.sv
// pp_fifo_wr_arbiter: round-robin arbiter of NUM_REQ writers onto one FIFO; burst lock via PP_FIFO_ARB_BURST_LOCK_EN
module pp_fifo_wr_arbiter
  import pp_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            req_full_n,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  input  logic                          fifo_full_n,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_vld
);
  localparam int IW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_cfg
    $error("pp_fifo_wr_arbiter: NUM_REQ or BURST_LEN out of range");
  end
  arb_state_e    state_q, state_d;
  logic [IW-1:0] gid_q, gid_d, last_q, last_d, base, start, pick_idx;
  logic [NUM_REQ-1:0] mask;
  logic          pick_vld, last_beat, rel, hold, open;
  assign grant_vld  = (state_q == ARB_GRANT);
  assign grant_id   = gid_q;
  assign open       = grant_vld & ~reset & fifo_full_n;
  assign fifo_write = open & req_write[gid_q];
  assign fifo_din   = req_din[int'(gid_q)*DATA_WIDTH +: DATA_WIDTH];
  assign req_full_n = open ? NUM_REQ'(1) << gid_q : '0;
`ifdef PP_FIFO_ARB_BURST_LOCK_EN
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  assign last_beat = fifo_write && (cnt_q == ARB_CNT_W'(BURST_LEN - 1));
  assign cnt_d     = (rel || !grant_vld) ? '0 : cnt_q + ARB_CNT_W'(fifo_write);
  // beats taken by the current owner; cleared whenever ownership changes
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
`else
  assign last_beat = fifo_write;
`endif
  assign rel   = grant_vld & (~req_write[gid_q] | last_beat);
  assign hold  = grant_vld & ~rel;
  assign base  = grant_vld ? gid_q : last_q;
  assign start = (base == IW'(NUM_REQ - 1)) ? '0 : base + 1'b1;
  assign mask  = grant_vld ? ~(NUM_REQ'(1) << gid_q) : '1;
  pp_rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (req_write),
    .mask_i  (mask),
    .start_i (start),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );
  assign state_d = (hold || pick_vld) ? ARB_GRANT : ARB_IDLE;
  assign gid_d   = (!hold && pick_vld) ? pick_idx : gid_q;
  assign last_d  = rel ? gid_q : last_q;
  // owner FSM; last_q starts at the top index so writer 0 wins the first pick
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      gid_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
    end
  end
endmodule
